result_collector: RTL and testbench

//   Downstream of the systolic accelerator top. Deserialises the result bitstream (data_out_z

---
 rtl/result_collector.sv | 191 +++++++++++++++++++
 tb/tb_result_collector.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// result_collector: turns the accelerator's serial result stream into indexed words.
// Incoming bits are MSB first on data_out_z and qualified by tx_ready. Each 2*D_W-bit
// word is tagged with its row-major element index and queued in a first-word-fall-through
// FIFO. The host reads the FIFO over a valid/ready interface.
// Ports:
//   clk, rst (async active-low), clear (sync flush of FIFO, counters and flags)
//   data_out_z, tx_ready           serial result input
//   m_data, m_idx, m_last, m_valid head-of-FIFO word, its element index and frame-last flag
//   m_ready                        consumer accept
//   frame_done                     one-cycle pulse when a frame's last word is pushed
//   overflow, frame_err            sticky: word dropped on full FIFO / frame truncated
module result_collector #(
  parameter  int unsigned D_W    = 8,
  parameter  int unsigned N      = 2,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned WORD_W = 2 * D_W,
  localparam int unsigned IDX_W  = (N > 1) ? $clog2(N * N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              data_out_z,
  input  logic              tx_ready,
  output logic [WORD_W-1:0] m_data,
  output logic [IDX_W-1:0]  m_idx,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              frame_done,
  output logic              overflow,
  output logic              frame_err
);

  localparam int unsigned BC_W  = $clog2(WORD_W);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              last;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

  state_t            r_state;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [IDX_W-1:0]  r_elem_idx;
  logic [WORD_W-2:0] r_shreg;
  logic              r_frame_done;
  logic              r_overflow;
  logic              r_frame_err;

  entry_t            r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_valid;

  logic [WORD_W-1:0] w_word;
  logic              w_word_end;
  logic              w_last_elem;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_wr_en;
  logic              w_drop;

  // Current bit completes the shift register into a full word.
  assign w_word      = {r_shreg, data_out_z};
  assign w_word_end  = (r_bit_cnt == BC_W'(WORD_W - 1));
  assign w_last_elem = (r_elem_idx == IDX_W'(N * N - 1));
  assign w_push      = (r_state == S_RECV) && tx_ready && w_word_end;
  assign w_pop       = r_valid && m_ready;
  assign w_full      = (r_count == CNT_W'(DEPTH));
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_wr_en     = w_push && (!w_full || w_pop);
  assign w_drop      = w_push && w_full && !w_pop;

  // Deserialiser FSM and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_elem_idx   <= '0;
      r_shreg      <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else if (clear) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_elem_idx   <= '0;
      r_shreg      <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The bit present when tx_ready first rises is bit 0 of the frame.
          if (tx_ready) begin
            r_shreg   <= w_word[WORD_W-2:0];
            r_bit_cnt <= BC_W'(1);
            r_state   <= S_RECV;
          end
        end
        S_RECV: begin
          if (tx_ready) begin
            r_shreg <= w_word[WORD_W-2:0];
            if (w_word_end) begin
              r_bit_cnt <= '0;
              if (w_last_elem) begin
                r_elem_idx   <= '0;
                r_frame_done <= 1'b1;
                r_state      <= S_DONE;
              end else begin
                r_elem_idx <= r_elem_idx + 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            // Stream stopped mid-frame: abandon the rest of it.
            if ((r_bit_cnt != '0) || (r_elem_idx != '0)) begin
              r_frame_err <= 1'b1;
            end
            r_bit_cnt  <= '0;
            r_elem_idx <= '0;
            r_state    <= S_IDLE;
          end
        end
        S_DONE: begin
          if (!tx_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Result FIFO; count register separates full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= '{data: w_word, idx: r_elem_idx, last: w_last_elem};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_en, w_pop})
        2'b10: begin
          r_count <= r_count + CNT_W'(1);
          r_valid <= 1'b1;
        end
        2'b01: begin
          r_count <= r_count - CNT_W'(1);
          r_valid <= (r_count != CNT_W'(1));
        end
        default: ;
      endcase
    end
  end

  assign m_data     = r_mem[r_rd_ptr].data;
  assign m_idx      = r_mem[r_rd_ptr].idx;
  assign m_last     = r_mem[r_rd_ptr].last;
  assign m_valid    = r_valid;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: scoreboard bench for result_collector (D_W=8, N=2, DEPTH=4).
// Expected words are queued as frames are driven; a negedge monitor pops and compares
// them whenever the DUT hands a word over (m_valid & m_ready).
module tb_result_collector;

  localparam int unsigned D_W   = 8;
  localparam int unsigned N     = 2;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        data_out_z;
  logic        tx_ready;
  logic [15:0] m_data;
  logic [1:0]  m_idx;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
  logic        frame_done;
  logic        overflow;
  logic        frame_err;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   fd_cnt = 0;
  int   fd0;

  result_collector #(.D_W(D_W), .N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .data_out_z (data_out_z),
    .tx_ready   (tx_ready),
    .m_data     (m_data),
    .m_idx      (m_idx),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .frame_done (frame_done),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Handover monitor and frame_done pulse counter.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && clear === 1'b0) begin
      if (frame_done === 1'b1) fd_cnt++;
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        check("sb_has_entry", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("word_data", 32'(m_data), 32'(e.data));
          check("word_idx",  32'(m_idx),  32'(e.idx));
          check("word_last", 32'(m_last), 32'(e.last));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] w, input int first, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      tx_ready   = 1'b1;
      data_out_z = w[15-first-i];
      tick();
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    send_bits(w, 0, 16);
  endtask

  task automatic gap(input int n);
    tx_ready   = 1'b0;
    data_out_z = 1'b0;
    repeat (n) tick();
  endtask

  task automatic expect_word(input logic [15:0] d, input logic [1:0] i);
    q.push_back('{data: d, idx: i, last: (i == 2'd3)});
  endtask

  task automatic send_frame(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3, input bit keep);
    if (keep) begin
      expect_word(w0, 2'd0);
      expect_word(w1, 2'd1);
      expect_word(w2, 2'd2);
      expect_word(w3, 2'd3);
    end
    send_word(w0);
    send_word(w1);
    send_word(w2);
    send_word(w3);
  endtask

  // Wait (bounded) for the scoreboard to empty, then the FIFO must be empty too.
  task automatic drain(input string tag);
    int k = 0;
    while (q.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    check({tag, "_drained"}, 32'(q.size()), 32'd0);
    check({tag, "_empty_after"}, 32'(m_valid), 32'd0);
  endtask

  task automatic do_clear();
    q.delete();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; clear = 1'b0; tx_ready = 1'b0; data_out_z = 1'b0; m_ready = 1'b0;
    repeat (2) tick();
    check("rst_valid",  32'(m_valid),    32'd0);
    check("rst_data",   32'(m_data),     32'd0);
    check("rst_idx",    32'(m_idx),      32'd0);
    check("rst_last",   32'(m_last),     32'd0);
    check("rst_done",   32'(frame_done), 32'd0);
    check("rst_ovf",    32'(overflow),   32'd0);
    check("rst_ferr",   32'(frame_err),  32'd0);
    rst = 1'b1;
    tick();

    // Basic frame with consumer always ready; first word latency and done pulse.
    m_ready = 1'b1;
    fd0 = fd_cnt;
    expect_word(16'h1234, 2'd0);
    expect_word(16'h0056, 2'd1);
    expect_word(16'hABCD, 2'd2);
    expect_word(16'hFFFF, 2'd3);
    send_word(16'h1234);
    check("t1_lat_valid", 32'(m_valid), 32'd1);
    check("t1_lat_data",  32'(m_data),  32'h1234);
    send_word(16'h0056);
    send_word(16'hABCD);
    send_word(16'hFFFF);
    check("t1_done_pulse", 32'(frame_done), 32'd1);
    gap(1);
    check("t1_done_low", 32'(frame_done), 32'd0);
    drain("t1");
    check("t1_done_count", 32'(fd_cnt - fd0), 32'd1);
    check("t1_ovf",  32'(overflow),  32'd0);
    check("t1_ferr", 32'(frame_err), 32'd0);

    // Two frames into a stalled FIFO: first frame kept, second dropped.
    m_ready = 1'b0;
    fd0 = fd_cnt;
    send_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1);
    gap(1);
    send_frame(16'h5555, 16'h6666, 16'h7777, 16'h8888, 1'b0);
    gap(2);
    check("t2_ovf",        32'(overflow), 32'd1);
    check("t2_valid",      32'(m_valid),  32'd1);
    check("t2_done_count", 32'(fd_cnt - fd0), 32'd2);
    m_ready = 1'b1;
    drain("t2");
    do_clear();

    // Truncated frame, then a clean frame.
    m_ready = 1'b1;
    fd0 = fd_cnt;
    expect_word(16'hA0A0, 2'd0);
    expect_word(16'hB0B0, 2'd1);
    send_word(16'hA0A0);
    send_word(16'hB0B0);
    send_bits(16'hC0C0, 0, 5);
    gap(2);
    check("t3_ferr",       32'(frame_err), 32'd1);
    check("t3_done_count", 32'(fd_cnt - fd0), 32'd0);
    drain("t3a");
    send_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b1);
    gap(1);
    drain("t3b");
    check("t3_ferr_sticky", 32'(frame_err), 32'd1);
    check("t3_ovf",         32'(overflow),  32'd0);
    do_clear();

    // Full FIFO with a pop on the very cycle a new word completes.
    m_ready = 1'b0;
    send_frame(16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04, 1'b1);
    gap(1);
    check("t4_full_valid", 32'(m_valid), 32'd1);
    expect_word(16'h0B01, 2'd0);
    expect_word(16'h0B02, 2'd1);
    expect_word(16'h0B03, 2'd2);
    expect_word(16'h0B04, 2'd3);
    send_bits(16'h0B01, 0, 15);
    m_ready = 1'b1;
    send_bits(16'h0B01, 15, 1);
    check("t4_ovf_edge", 32'(overflow), 32'd0);
    send_word(16'h0B02);
    send_word(16'h0B03);
    send_word(16'h0B04);
    gap(1);
    drain("t4");
    check("t4_ovf", 32'(overflow), 32'd0);

    // Asynchronous reset in the middle of a word with data buffered.
    m_ready = 1'b0;
    send_frame(16'h1357, 16'h2468, 16'h3579, 16'h468A, 1'b0);
    gap(1);
    send_bits(16'h9999, 0, 7);
    #2 rst = 1'b0;
    #1;
    check("t5_valid", 32'(m_valid),    32'd0);
    check("t5_data",  32'(m_data),     32'd0);
    check("t5_ovf",   32'(overflow),   32'd0);
    check("t5_ferr",  32'(frame_err),  32'd0);
    check("t5_done",  32'(frame_done), 32'd0);
    tx_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    m_ready = 1'b1;
    send_frame(16'h2468, 16'h1357, 16'h0F0F, 16'hF0F0, 1'b1);
    gap(1);
    drain("t5");
    check("t5_ferr_after", 32'(frame_err), 32'd0);

    // Clear with three words buffered and both sticky flags set.
    m_ready = 1'b0;
    send_frame(16'hC001, 16'hC002, 16'hC003, 16'hC004, 1'b1);
    gap(1);
    send_word(16'h7777);
    gap(1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("t6_pre_ovf",   32'(overflow),  32'd1);
    check("t6_pre_ferr",  32'(frame_err), 32'd1);
    check("t6_pre_valid", 32'(m_valid),   32'd1);
    check("t6_pre_data",  32'(m_data),    32'hC002);
    do_clear();
    check("t6_valid", 32'(m_valid),   32'd0);
    check("t6_ovf",   32'(overflow),  32'd0);
    check("t6_ferr",  32'(frame_err), 32'd0);
    check("t6_data",  32'(m_data),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
